// File: rtl/fir_resampler_out_buf_if.sv
// Sample path of the resampler output buffer: upstream strobe side plus the downstream
// valid/ready stream. The buffer takes the master modport, the consumer the slave modport.
interface fir_resampler_out_buf_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] data;
    logic                  data_val;
    logic [1:0]            err_flg;
    logic [DATA_WIDTH-1:0] m_data;
    logic [1:0]            m_err;
    logic                  m_valid;
    logic                  m_ready;

    modport master (
        input  data, data_val, err_flg, m_ready,
        output m_data, m_err, m_valid
    );

    modport slave (
        output data, data_val, err_flg, m_ready,
        input  m_data, m_err, m_valid
    );
endinterface

// File: rtl/fir_resampler_out_buf.sv
// Output buffer for the FIR resampler: absorbs non-backpressurable sample strobes into a FIFO
// (RAM plus output register) and re-presents them on a valid/ready stream with sticky status.
module fir_resampler_out_buf #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned AFULL_LVL  = DEPTH - 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    fir_resampler_out_buf_if.master bus,
    input  logic                   clr_i,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   afull_o,
    output logic                   ovf_o,
    output logic [1:0]             err_sticky_o
);

    localparam int unsigned AWIDTH    = $clog2(DEPTH);
    localparam int unsigned RAM_WORDS = DEPTH - 1;
    localparam logic [AWIDTH:0]   LVL_FULL  = (AWIDTH + 1)'(DEPTH);
    localparam logic [AWIDTH:0]   LVL_AFULL = (AWIDTH + 1)'(AFULL_LVL);
    localparam logic [AWIDTH-1:0] PTR_LAST  = AWIDTH'(RAM_WORDS - 1);

    typedef enum logic {StEmpty, StPresent} out_state_e;

    out_state_e state_q, state_d;

    logic [DATA_WIDTH+1:0] mem_q [RAM_WORDS];
    logic [DATA_WIDTH+1:0] out_q;
    logic [AWIDTH-1:0]     wr_ptr_q, rd_ptr_q, ram_cnt_q;
    logic [AWIDTH:0]       level_q, level_d;
    logic                  afull_q;
    logic                  ovf_q, ovf_d;
    logic [1:0]            err_q, err_d;

    logic transfer, accept, drop, ram_empty, pop, push, bypass;

    always_comb begin
        transfer  = (state_q == StPresent) & bus.m_ready;
        ram_empty = (ram_cnt_q == '0);
        // A full buffer still takes a sample when the head leaves in the same cycle.
        accept    = bus.data_val & ((level_q != LVL_FULL) | transfer);
        drop      = bus.data_val & ~accept;

        state_d = state_q;
        pop     = 1'b0;
        bypass  = 1'b0;
        case (state_q)
            StEmpty: begin
                if (!ram_empty) begin
                    pop     = 1'b1;
                    state_d = StPresent;
                end else if (accept) begin
                    bypass  = 1'b1;
                    state_d = StPresent;
                end
            end
            StPresent: begin
                if (transfer) begin
                    if (!ram_empty) begin
                        pop = 1'b1;
                    end else if (accept) begin
                        bypass = 1'b1;
                    end else begin
                        state_d = StEmpty;
                    end
                end
            end
        endcase
        push = accept & ~bypass;

        level_d = level_q + {{AWIDTH{1'b0}}, accept} - {{AWIDTH{1'b0}}, transfer};
        // Clear first, then OR in this cycle's events so a coincident set wins.
        ovf_d   = (clr_i ? 1'b0 : ovf_q) | drop;
        err_d   = (clr_i ? 2'b00 : err_q) | (accept ? bus.err_flg : 2'b00);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StEmpty;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ram_cnt_q <= '0;
            level_q   <= '0;
            out_q     <= '0;
            afull_q   <= 1'b0;
            ovf_q     <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            afull_q <= (level_d >= LVL_AFULL);
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + AWIDTH'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + AWIDTH'(1);
            end
            if (push && !pop) begin
                ram_cnt_q <= ram_cnt_q + AWIDTH'(1);
            end else if (pop && !push) begin
                ram_cnt_q <= ram_cnt_q - AWIDTH'(1);
            end
            // When full, push and pop share an address; the read sees the old word.
            if (pop) begin
                out_q <= mem_q[rd_ptr_q];
            end else if (bypass) begin
                out_q <= {bus.err_flg, bus.data};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.err_flg, bus.data};
        end
    end

    assign bus.m_valid   = (state_q == StPresent);
    assign bus.m_data    = out_q[DATA_WIDTH-1:0];
    assign bus.m_err     = out_q[DATA_WIDTH+1:DATA_WIDTH];
    assign level_o       = level_q;
    assign afull_o       = afull_q;
    assign ovf_o         = ovf_q;
    assign err_sticky_o  = err_q;

endmodule

// File: tb/tb_fir_resampler_out_buf.sv
// Scoreboard bench for fir_resampler_out_buf: directed scenarios followed by a random
// strobe/ready phase, with expected samples queued at issue and checked at the output.
module tb_fir_resampler_out_buf;

    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam int AFULL = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic [4:0] level;
    logic       afull, ovf;
    logic [1:0] err_sticky;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW+1:0] exp_q [$];
    int            mlevel = 0;
    logic          movf   = 1'b0;
    logic [1:0]    merr   = 2'b00;

    fir_resampler_out_buf_if #(.DATA_WIDTH(DW)) bus ();

    fir_resampler_out_buf #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .AFULL_LVL (AFULL)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (bus),
        .clr_i       (clr),
        .level_o     (level),
        .afull_o     (afull),
        .ovf_o       (ovf),
        .err_sticky_o(err_sticky)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: state reflects DUT outputs after the last edge; updated from the
    // inputs that will be sampled at the next edge.
    always @(negedge clk) begin
        bit xfer, acc;
        if (rst) begin
            exp_q.delete();
            mlevel = 0;
            movf   = 1'b0;
            merr   = 2'b00;
        end else begin
            check("level", 32'(level), 32'(mlevel));
            check("m_valid", 32'(bus.m_valid), 32'(mlevel != 0));
            check("afull", 32'(afull), 32'(mlevel >= AFULL));
            check("ovf", 32'(ovf), 32'(movf));
            check("err_sticky", 32'(err_sticky), 32'(merr));
            xfer = (mlevel != 0) && bus.m_ready;
            acc  = bus.data_val && ((mlevel < DEPTH) || xfer);
            if (acc) exp_q.push_back({bus.err_flg, bus.data});
            mlevel = mlevel + int'(acc) - int'(xfer);
            movf   = (clr ? 1'b0 : movf) | (bus.data_val && !acc);
            merr   = (clr ? 2'b00 : merr) | (acc ? bus.err_flg : 2'b00);
        end
    end

    // Output monitor: every accepted transfer must match the oldest expected sample.
    always @(negedge clk) begin
        logic [DW+1:0] e;
        if (!rst && bus.m_valid && bus.m_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_output at %0t: got %0h, expected no sample",
                         $time, bus.m_data);
            end else begin
                e = exp_q.pop_front();
                check("m_data", 32'(bus.m_data), 32'(e[DW-1:0]));
                check("m_err", 32'(bus.m_err), 32'(e[DW+1:DW]));
            end
        end
    end

    initial begin
        bus.data     = '0;
        bus.data_val = 1'b0;
        bus.err_flg  = 2'b00;
        bus.m_ready  = 1'b0;
        tick();
        tick();
        check("rst_m_valid", 32'(bus.m_valid), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_m_data", 32'(bus.m_data), 32'd0);
        check("rst_flags", {28'd0, afull, ovf, err_sticky}, 32'd0);
        rst = 1'b0;

        // Latency: one strobe at level 0 appears the next cycle, then leaves.
        bus.m_ready = 1'b1;
        bus.data = 16'h1234; bus.err_flg = 2'b00; bus.data_val = 1'b1;
        tick();
        bus.data_val = 1'b0;
        check("t1_valid", 32'(bus.m_valid), 32'd1);
        check("t1_data", 32'(bus.m_data), 32'h1234);
        tick();
        check("t1_empty", 32'(bus.m_valid), 32'd0);

        // Fill while stalled, then overflow with one extra strobe.
        bus.m_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.data = 16'(i); bus.data_val = 1'b1;
            tick();
        end
        check("t2_level", 32'(level), 32'd16);
        check("t2_afull", 32'(afull), 32'd1);
        bus.data = 16'hDEAD;
        tick();
        bus.data_val = 1'b0;
        check("t3_ovf", 32'(ovf), 32'd1);
        check("t3_level", 32'(level), 32'd16);
        bus.m_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("t2_drain_data", 32'(bus.m_data), 32'(i));
            tick();
        end
        check("t2_drained", 32'(level), 32'd0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("t3_clr", 32'(ovf), 32'd0);

        // Full with a simultaneous transfer accepts the new sample.
        bus.m_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.data = 16'(16'h0100 + i); bus.data_val = 1'b1;
            tick();
        end
        bus.m_ready = 1'b1; bus.data = 16'h00AA;
        tick();
        bus.data_val = 1'b0;
        check("t4_ovf", 32'(ovf), 32'd0);
        check("t4_level", 32'(level), 32'd16);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) check("t4_last", 32'(bus.m_data), 32'h00AA);
            tick();
        end

        // Error flags travel per sample and accumulate in the sticky status.
        bus.m_ready = 1'b0;
        bus.data = 16'h0001; bus.err_flg = 2'b01; bus.data_val = 1'b1;
        tick();
        bus.data = 16'h0002; bus.err_flg = 2'b10;
        tick();
        bus.data_val = 1'b0; bus.err_flg = 2'b00;
        check("t5_sticky", 32'(err_sticky), 32'b11);
        check("t5_m_err0", 32'(bus.m_err), 32'b01);
        bus.m_ready = 1'b1;
        tick();
        check("t5_m_err1", 32'(bus.m_err), 32'b10);
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("t5_clr", 32'(err_sticky), 32'b00);
        clr = 1'b1; bus.data = 16'h0003; bus.err_flg = 2'b01; bus.data_val = 1'b1;
        tick();
        clr = 1'b0; bus.data_val = 1'b0; bus.err_flg = 2'b00;
        check("t5_set_wins", 32'(err_sticky), 32'b01);
        tick();

        // Reset in the middle of a drain.
        bus.m_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            bus.data = 16'(16'h0700 + i); bus.data_val = 1'b1;
            tick();
        end
        bus.data_val = 1'b0; bus.m_ready = 1'b1;
        tick();
        tick();
        check("t6_level7", 32'(level), 32'd7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_valid", 32'(bus.m_valid), 32'd0);
        check("t6_level", 32'(level), 32'd0);
        check("t6_ovf", 32'(ovf), 32'd0);
        bus.data = 16'h5A5A; bus.data_val = 1'b1;
        tick();
        bus.data_val = 1'b0;
        check("t6_new_valid", 32'(bus.m_valid), 32'd1);
        check("t6_new_data", 32'(bus.m_data), 32'h5A5A);
        tick();
        check("t6_new_empty", 32'(bus.m_valid), 32'd0);

        // Random strobe/ready traffic across several ready/strobe densities.
        for (int ph = 0; ph < 4; ph++) begin
            int rdy_pct, val_pct;
            rdy_pct = (ph == 0) ? 90 : (ph == 1) ? 30 : (ph == 2) ? 60 : 10;
            val_pct = (ph == 3) ? 80 : 50;
            for (int c = 0; c < 800; c++) begin
                bus.data     = 16'($urandom);
                bus.err_flg  = 2'($urandom_range(0, 3));
                bus.data_val = ($urandom_range(0, 99) < val_pct);
                bus.m_ready  = ($urandom_range(0, 99) < rdy_pct);
                clr          = ($urandom_range(0, 31) == 0);
                tick();
            end
        end
        bus.data_val = 1'b0; clr = 1'b0; bus.m_ready = 1'b1;
        repeat (20) tick();
        check("final_level", 32'(level), 32'd0);
        check("final_queue", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
